// File: rtl/dro_bank.sv
// Multi-channel destructive-readout (DRO) storage bank with a shared SFQ clock.
// Each stage tracks {0, 1, X}. Setup and hold windows are checked per channel.
module dro_bank #(
   parameter int unsigned CH      = 4,
   parameter int unsigned DEPTH   = 2,
   parameter int unsigned T_SETUP = 8,
   parameter int unsigned T_HOLD  = 3,
   parameter int unsigned DELAY   = 13,
   parameter int unsigned PW      = 2,
   parameter int unsigned MODE    = 0,
   parameter int unsigned CNT_W   = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [CH-1:0]    d,
   input  logic             clk_sfq,
   input  logic             clr_viol,
   output logic [CH-1:0]    out,
   output logic [CH-1:0]    out_x,
   output logic [CH-1:0]    viol,
   output logic [CNT_W-1:0] viol_cnt
);
   localparam int unsigned DL     = DELAY + PW - 1;
   localparam int unsigned SC_W   = $clog2(T_HOLD + 2);
   localparam int unsigned TM_W   = $clog2(T_SETUP + 2);
   localparam int unsigned CntMax = 32'((64'd1 << CNT_W) - 64'd1);
   localparam logic [SC_W-1:0] SinceMax = SC_W'(T_HOLD);
   localparam logic [TM_W-1:0] TmrLoad  = TM_W'((T_SETUP > 0) ? T_SETUP - 1 : 0);

   logic [SC_W-1:0]           since_q, since_d, since_now;
   logic [CH-1:0][DEPTH-1:0]  sv_q, sv_d, sx_q, sx_d;
   logic [CH-1:0]             pend_q, pend_d;
   logic [CH-1:0][TM_W-1:0]   tmr_q, tmr_d;
   logic [CH-1:0][DL-1:0]     dv_q, dv_d, dx_q, dx_d;
   logic [CH-1:0]             viol_q, viol_d;
   logic [CNT_W-1:0]          cnt_q, cnt_d;
   logic                      hold_win, hold_v, acc, due, setup_v, commit;
   int unsigned               n_viol;

   always_comb begin
      // A d pulse coincident with clk_sfq sees since_clk = 0.
      since_now = clk_sfq ? '0 : since_q;
      since_d   = (since_now == SinceMax) ? SinceMax : since_now + 1'b1;
      hold_win  = (since_now < SinceMax);
      sv_d      = sv_q;
      sx_d      = sx_q;
      pend_d    = pend_q;
      tmr_d     = tmr_q;
      dv_d      = dv_q;
      dx_d      = dx_q;
      viol_d    = '0;
      hold_v    = 1'b0;
      acc       = 1'b0;
      due       = 1'b0;
      setup_v   = 1'b0;
      commit    = 1'b0;
      for (int c = 0; c < CH; c++) begin
         hold_v  = d[c] & hold_win;
         acc     = d[c] & ~hold_win;
         due     = pend_q[c] & (tmr_q[c] == '0);
         setup_v = clk_sfq & (pend_q[c] | acc);
         commit  = 1'b0;
         if (clk_sfq) begin
            pend_d[c] = 1'b0;
         end else if (acc) begin
            // A new pulse restarts the window and supersedes any commit due now.
            if (T_SETUP == 0) begin
               commit = 1'b1;
            end else begin
               pend_d[c] = 1'b1;
               tmr_d[c]  = TmrLoad;
            end
         end else if (pend_q[c]) begin
            if (due) begin
               commit    = 1'b1;
               pend_d[c] = 1'b0;
            end else begin
               tmr_d[c] = tmr_q[c] - 1'b1;
            end
         end

         if (clk_sfq) begin
            for (int k = DEPTH - 1; k > 0; k--) begin
               sv_d[c][k] = sv_q[c][k-1];
               sx_d[c][k] = sx_q[c][k-1];
            end
            sv_d[c][0] = (MODE == 1) ? sv_q[c][DEPTH-1] : 1'b0;
            sx_d[c][0] = (MODE == 1) ? sx_q[c][DEPTH-1] : 1'b0;
         end
         if (commit && !sx_q[c][0]) begin
            sv_d[c][0] = 1'b1;
         end
         if (hold_v || setup_v) begin
            sv_d[c][0] = 1'b0;
            sx_d[c][0] = 1'b1;
         end
         viol_d[c] = hold_v | setup_v;

         for (int j = DL - 1; j > 0; j--) begin
            dv_d[c][j] = dv_q[c][j-1];
            dx_d[c][j] = dx_q[c][j-1];
         end
         dv_d[c][0] = clk_sfq & sv_q[c][DEPTH-1] & ~sx_q[c][DEPTH-1];
         dx_d[c][0] = clk_sfq & sx_q[c][DEPTH-1];
      end
   end

   always_comb begin
      n_viol = 0;
      for (int c = 0; c < CH; c++) begin
         n_viol = n_viol + 32'(viol_d[c]);
      end
      if (clr_viol) begin
         cnt_d = '0;
      end else if (n_viol > CntMax - 32'(cnt_q)) begin
         cnt_d = CNT_W'(CntMax);
      end else begin
         cnt_d = cnt_q + CNT_W'(n_viol);
      end
   end

   always_comb begin
      out   = '0;
      out_x = '0;
      for (int c = 0; c < CH; c++) begin
         out[c]   = |(dv_q[c][DL-1:DELAY-1] & ~dx_q[c][DL-1:DELAY-1]);
         out_x[c] = |dx_q[c][DL-1:DELAY-1];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         since_q <= SinceMax;
         sv_q    <= '0;
         sx_q    <= '0;
         pend_q  <= '0;
         tmr_q   <= '0;
         dv_q    <= '0;
         dx_q    <= '0;
         viol_q  <= '0;
         cnt_q   <= '0;
      end else begin
         since_q <= since_d;
         sv_q    <= sv_d;
         sx_q    <= sx_d;
         pend_q  <= pend_d;
         tmr_q   <= tmr_d;
         dv_q    <= dv_d;
         dx_q    <= dx_d;
         viol_q  <= viol_d;
         cnt_q   <= cnt_d;
      end
   end

   assign viol     = viol_q;
   assign viol_cnt = cnt_q;

endmodule

// File: tb/tb_dro_bank.sv
// Directed bench for dro_bank: destructive default instance plus a recirculating
// instance with a 2-bit violation counter, each with hand-derived per-cycle expectations.
module tb_dro_bank;
   logic       clk = 1'b0;
   logic       rst0_n, rst1_n;
   logic [3:0] d0, d1;
   logic       sfq0, sfq1, clr0, clr1;
   logic [3:0] out0, outx0, viol0, out1, outx1, viol1;
   logic [7:0] cnt0;
   logic [1:0] cnt1;
   int         n_chk = 0;
   int         n_bad = 0;
   int         cyc   = 0;

   always #5 clk = ~clk;

   dro_bank u_dut0 (
      .clk      (clk),
      .rst_n    (rst0_n),
      .d        (d0),
      .clk_sfq  (sfq0),
      .clr_viol (clr0),
      .out      (out0),
      .out_x    (outx0),
      .viol     (viol0),
      .viol_cnt (cnt0)
   );

   dro_bank #(
      .MODE  (1),
      .CNT_W (2)
   ) u_dut1 (
      .clk      (clk),
      .rst_n    (rst1_n),
      .d        (d1),
      .clk_sfq  (sfq1),
      .clr_viol (clr1),
      .out      (out1),
      .out_x    (outx1),
      .viol     (viol1),
      .viol_cnt (cnt1)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
      end
   endtask

   // Destructive instance: 1 launched @50, X launched @140 and @240, 1 launched @260;
   // the 1 launched @300 is wiped by the reset @305.
   function automatic logic [3:0] exp_out0(input int c);
      exp_out0 = '0;
      if (c == 63 || c == 64)   exp_out0[0] = 1'b1;
      if (c == 273 || c == 274) exp_out0[2] = 1'b1;
   endfunction

   function automatic logic [3:0] exp_outx0(input int c);
      exp_outx0 = '0;
      if (c == 153 || c == 154) exp_outx0[1] = 1'b1;
      if (c == 253 || c == 254) exp_outx0[2] = 1'b1;
   endfunction

   function automatic logic [3:0] exp_viol0(input int c);
      exp_viol0 = '0;
      if (c == 101) exp_viol0[1] = 1'b1;
      if (c == 203) exp_viol0[2] = 1'b1;
   endfunction

   function automatic logic [7:0] exp_cnt0(input int c);
      if (c < 101)       exp_cnt0 = 8'd0;
      else if (c < 203)  exp_cnt0 = 8'd1;
      else if (c <= 305) exp_cnt0 = 8'd2;
      else               exp_cnt0 = 8'd0;
   endfunction

   // Recirculating instance: the ring bit launches on every second clk_sfq (50, 90, ...).
   function automatic logic [3:0] exp_out1(input int c);
      exp_out1 = '0;
      if (c >= 63 && c <= 264 && ((c - 63) % 40) <= 1) exp_out1[3] = 1'b1;
   endfunction

   function automatic logic [3:0] exp_viol1(input int c);
      exp_viol1 = '0;
      if (c == 272 || c == 333) exp_viol1[0] = 1'b1;
      if (c == 292 || c == 352) exp_viol1[1] = 1'b1;
      if (c == 312)             exp_viol1[2] = 1'b1;
   endfunction

   function automatic logic [1:0] exp_cnt1(input int c);
      if (c < 272)       exp_cnt1 = 2'd0;
      else if (c < 292)  exp_cnt1 = 2'd1;
      else if (c < 312)  exp_cnt1 = 2'd2;
      else if (c <= 340) exp_cnt1 = 2'd3;
      else               exp_cnt1 = 2'd0;
   endfunction

   initial begin
      rst0_n = 1'b0;
      rst1_n = 1'b0;
      d0     = '0;
      d1     = '0;
      sfq0   = 1'b0;
      sfq1   = 1'b0;
      clr0   = 1'b0;
      clr1   = 1'b0;
      for (int c = 0; c < 370; c++) begin
         @(negedge clk);
         cyc = c;
         if (c >= 1) begin
            check_eq("d0_out",  32'(out0),  32'(exp_out0(c)));
            check_eq("d0_outx", 32'(outx0), 32'(exp_outx0(c)));
            check_eq("d0_viol", 32'(viol0), 32'(exp_viol0(c)));
            check_eq("d0_cnt",  32'(cnt0),  32'(exp_cnt0(c)));
            if (c <= 265) begin
               check_eq("d1_out",  32'(out1),  32'(exp_out1(c)));
               check_eq("d1_outx", 32'(outx1), 32'(4'b0000));
            end
            check_eq("d1_viol", 32'(viol1), 32'(exp_viol1(c)));
            check_eq("d1_cnt",  32'(cnt1),  32'(exp_cnt1(c)));
         end
         rst0_n = !(c < 3 || c == 305 || c == 306);
         rst1_n = !(c < 3);
         sfq0   = (c == 30 || c == 50 || c == 100 || c == 120 || c == 140 || c == 200 ||
                   c == 220 || c == 240 || c == 260 || c == 280 || c == 300);
         d0     = '0;
         d0[0]  = (c == 10 || c == 270);
         d0[1]  = (c == 95);
         d0[2]  = (c == 202 || c == 223);
         sfq1   = (c >= 30 && c <= 350 && ((c - 30) % 20) == 0);
         d1     = '0;
         d1[0]  = (c == 271 || c == 332);
         d1[1]  = (c == 291 || c == 351);
         d1[2]  = (c == 311);
         d1[3]  = (c == 10);
         clr1   = (c == 340 || c == 351);
      end
      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
